smt_dispatch_scheduler: RTL and testbench
=========================================

SMT_DISPATCH_SCHEDULER -- requirements
Module: smt_dispatch_scheduler

Interface
REQ-001 Parameters SHALL be:
  FLUSH_CYCLES, 2, cycles a thread is blocked after mispredict
  STARVE_LIMIT, 4, consecutive zero-grant eligible cycles before forced priority
REQ-002 Ports SHALL be:
  clock  in  1  single clock, all state on rising edge
  reset  in  1  synchronous, active-low (0 = reset)
  req_0 / req_1  in  1  thread t has at least one decoded instruction ready
  num_ready_0 / num_ready_1  in  2  instructions available from thread t (0..2)
  uses_RS_0 / uses_RS_1  in  2  bit k: thread t's k-th oldest instruction needs an RS entry
  uses_LSQ_0 / uses_LSQ_1  in  2  bit k: thread t's k-th oldest instruction needs an LSQ entry
  ROB_0_full, ROB_0_almost_full, ROB_1_full, ROB_1_almost_full  in  1  per-thread ROB status
  RS_full, RS_almost_full, LSQ_full, LSQ_almost_full  in  1  shared status; almost_full = exactly one free entry
  mispredict_ROB_0 / mispredict_ROB_1  in  1  flush of thread t
  slot_valid  out  2  dispatch slot s carries an instruction
  slot_thread  out  2  bit s: thread owning slot s
  consume_0 / consume_1  out  2  instructions taken from thread t this cycle (0..2)
  stall_0 / stall_1  out  1  req_t and consume_t < num_ready_t

Function
REQ-003 Thread t SHALL be eligible iff req_t, state_t = RUN, !ROB_t_full, and !mispredict_ROB_t.
REQ-004 Per-thread cap: 0 if ineligible; 1 if ROB_t_almost_full; else min(num_ready_t, 2).
REQ-005 Within a thread, instructions SHALL issue strictly oldest-first; blocking instruction k blocks k+1 in that cycle.
REQ-006 Shared budgets: RS and LSQ each allow 0 grants if full, 1 if almost_full, else 2; debited in slot order (slot 0 before slot 1).
REQ-007 Fill order: favoured thread takes slot 0 and as many further slots as cap and budgets allow; remaining slot goes to the other thread's oldest instruction if allowed.
REQ-008 Favoured thread SHALL be the starving thread if exactly one starve counter equals STARVE_LIMIT; else rr_ptr.
REQ-009 rr_ptr SHALL toggle only in cycles where both threads are eligible and at least one grant is made.
REQ-010 Starve counter t SHALL increment (saturating at STARVE_LIMIT) when thread t is eligible with consume_t = 0, and clear when consume_t > 0 or thread t is ineligible.
REQ-011 slot_valid SHALL be packed: slot 1 is never valid while slot 0 is invalid.
REQ-012 Per-thread FSM: RUN -> FLUSH on mispredict_ROB_t; FLUSH counts FLUSH_CYCLES cycles, then -> RUN; a mispredict during FLUSH restarts the count.
REQ-013 A mispredict on one thread SHALL NOT affect grants to the other thread in the same cycle.
REQ-014 Outputs SHALL be combinational from current state and inputs (zero latency); only rr_ptr, FSM states, flush counters and starve counters are registered.

Reset
REQ-015 With reset = 0 at a clock edge: rr_ptr = 0, both FSMs = RUN, all counters = 0.
REQ-016 While reset = 0: slot_valid = 0, consume_t = 0, stall_t = 0.
REQ-017 Reset during FLUSH SHALL return the thread to RUN with no residual count.

Structure
REQ-018 Thread-state enum (RUN, FLUSH), the N_THREADS constant and default FLUSH_CYCLES / STARVE_LIMIT values SHALL reside in the shared sys_defs package.
REQ-019 The per-thread flush FSM plus its counter SHALL be sub-module thread_flush_fsm, instantiated twice.

Verification
REQ-020 Both threads eligible, num_ready = 2/2, no resource limits, rr_ptr = 0 -> slot_thread = 00, consume_0 = 2, consume_1 = 0, stall_1 = 1; next cycle slot_thread = 11.
REQ-021 ROB_0_almost_full = 1, both num_ready = 2, rr_ptr = 0 -> slot_thread = 10, consume_0 = 1, consume_1 = 1.
REQ-022 RS_almost_full = 1, uses_RS_0 = 11, thread 1 not requesting -> consume_0 = 1, slot_valid = 01, stall_0 = 1.
REQ-023 mispredict_ROB_0 pulse at cycle N -> thread 0 gets no grants in cycles N, N+1, N+2; grants resume at N+3 while thread 1 dispatches throughout.
REQ-024 Thread 1 eligible but LSQ_full blocks it for 4 cycles while thread 0 dispatches, then LSQ frees -> thread 1 favoured (slot 0) regardless of rr_ptr.
REQ-025 Assert reset = 0 mid-FLUSH with req high -> slot_valid = 00; after reset = 1, thread dispatches in the first cycle.

Source files
------------

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared types, constants and helpers for the SMT dispatch scheduler
// Purpose: thread-state enum, thread count, default timing parameters and the
// small combinational helpers used for per-thread caps and shared budgets.
// Ports: none (package).
package sys_defs;

  localparam int N_THREADS            = 2;
  localparam int DEFAULT_FLUSH_CYCLES = 2;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef enum logic {
    THR_RUN   = 1'b0,
    THR_FLUSH = 1'b1
  } thread_state_e;

  // Grants a shared queue can absorb this cycle.
  function automatic logic [1:0] budget(input logic full, input logic almost_full);
    if (full)             return 2'd0;
    else if (almost_full) return 2'd1;
    else                  return 2'd2;
  endfunction

  // Instructions a thread may offer this cycle.
  function automatic logic [1:0] thread_cap(input logic eligible, input logic rob_almost_full,
                                            input logic [1:0] num_ready);
    if (!eligible)            return 2'd0;
    else if (rob_almost_full) return 2'd1;
    else if (num_ready > 2'd2) return 2'd2;
    else                      return num_ready;
  endfunction

  // True when an instruction's queue needs are covered by the remaining budgets.
  function automatic logic fits(input logic need_rs, input logic need_lsq,
                                input logic [1:0] rs_left, input logic [1:0] lsq_left);
    return (!need_rs || (rs_left != 2'd0)) && (!need_lsq || (lsq_left != 2'd0));
  endfunction

endpackage

// File: rtl/thread_flush_fsm.sv
// rtl/thread_flush_fsm.sv - per-thread RUN/FLUSH state machine with flush counter
// Purpose: blocks a thread for FLUSH_CYCLES cycles after a mispredict; a new
// mispredict while flushing restarts the count.
// Ports: clk_i clock, rst_ni sync active-low reset, mispredict_i flush request,
//        state_o registered thread state.
module thread_flush_fsm
  import sys_defs::*;
#(
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          mispredict_i,
  output thread_state_e state_o
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  thread_state_e state_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= THR_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        THR_RUN: begin
          if (mispredict_i) begin
            state_q <= THR_FLUSH;
            cnt_q   <= '0;
          end
        end
        THR_FLUSH: begin
          if (mispredict_i) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
            state_q <= THR_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= THR_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/smt_dispatch_scheduler.sv
// rtl/smt_dispatch_scheduler.sv - two-thread, two-slot dispatch scheduler
// Purpose: picks up to two instructions per cycle from two threads, honouring
// per-thread ROB limits, shared RS/LSQ budgets, flush blocking, round-robin
// fairness and starvation override. Grant outputs are combinational.
// Ports: clock/reset (sync active-low); per-thread req, num_ready, uses_RS,
//        uses_LSQ, ROB status and mispredict; shared RS/LSQ status;
//        outputs slot_valid, slot_thread, consume_t, stall_t.
module smt_dispatch_scheduler
  import sys_defs::*;
#(
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_0,
  input  logic       req_1,
  input  logic [1:0] num_ready_0,
  input  logic [1:0] num_ready_1,
  input  logic [1:0] uses_RS_0,
  input  logic [1:0] uses_RS_1,
  input  logic [1:0] uses_LSQ_0,
  input  logic [1:0] uses_LSQ_1,
  input  logic       ROB_0_full,
  input  logic       ROB_0_almost_full,
  input  logic       ROB_1_full,
  input  logic       ROB_1_almost_full,
  input  logic       RS_full,
  input  logic       RS_almost_full,
  input  logic       LSQ_full,
  input  logic       LSQ_almost_full,
  input  logic       mispredict_ROB_0,
  input  logic       mispredict_ROB_1,
  output logic [1:0] slot_valid,
  output logic [1:0] slot_thread,
  output logic [1:0] consume_0,
  output logic [1:0] consume_1,
  output logic       stall_0,
  output logic       stall_1
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  thread_state_e        state [N_THREADS];
  logic [N_THREADS-1:0] req, mispredict, rob_full, rob_af, elig, starve_hit;
  logic [1:0]           num_ready [N_THREADS];
  logic [1:0]           uses_rs   [N_THREADS];
  logic [1:0]           uses_lsq  [N_THREADS];
  logic [1:0]           cap       [N_THREADS];
  logic [1:0]           cons      [N_THREADS];

  logic          rr_q, rr_d;
  logic [SW-1:0] starve_q [N_THREADS];
  logic [SW-1:0] starve_d [N_THREADS];

  logic       fav, oth;
  logic       f0, f1, o0, o1;
  logic [1:0] rs_left, lsq_left, gcnt_f, gcnt_o;
  logic [1:0] sv_c, st_c;

  assign req        = {req_1, req_0};
  assign mispredict = {mispredict_ROB_1, mispredict_ROB_0};
  assign rob_full   = {ROB_1_full, ROB_0_full};
  assign rob_af     = {ROB_1_almost_full, ROB_0_almost_full};
  assign num_ready[0] = num_ready_0;
  assign num_ready[1] = num_ready_1;
  assign uses_rs[0]   = uses_RS_0;
  assign uses_rs[1]   = uses_RS_1;
  assign uses_lsq[0]  = uses_LSQ_0;
  assign uses_lsq[1]  = uses_LSQ_1;

  thread_flush_fsm #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_0 (
    .clk_i        (clock),
    .rst_ni       (reset),
    .mispredict_i (mispredict_ROB_0),
    .state_o      (state[0])
  );

  thread_flush_fsm #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_1 (
    .clk_i        (clock),
    .rst_ni       (reset),
    .mispredict_i (mispredict_ROB_1),
    .state_o      (state[1])
  );

  // A mispredict in the current cycle already disqualifies its own thread only.
  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      elig[t]       = req[t] && (state[t] == THR_RUN) && !rob_full[t] && !mispredict[t];
      cap[t]        = thread_cap(elig[t], rob_af[t], num_ready[t]);
      starve_hit[t] = (starve_q[t] == SW'(STARVE_LIMIT));
    end
  end

  // Starvation overrides round-robin only when exactly one thread is starving.
  assign fav = (starve_hit == 2'b01) ? 1'b0 :
               (starve_hit == 2'b10) ? 1'b1 : rr_q;
  assign oth = ~fav;

  // Favoured thread fills from slot 0; the other thread continues into whatever
  // slots remain. Within a thread, a blocked instruction stops younger ones.
  always_comb begin
    rs_left  = budget(RS_full, RS_almost_full);
    lsq_left = budget(LSQ_full, LSQ_almost_full);

    f0       = (cap[fav] != 2'd0) && fits(uses_rs[fav][0], uses_lsq[fav][0], rs_left, lsq_left);
    rs_left  = rs_left  - {1'b0, f0 & uses_rs[fav][0]};
    lsq_left = lsq_left - {1'b0, f0 & uses_lsq[fav][0]};

    f1       = f0 && (cap[fav] == 2'd2) && fits(uses_rs[fav][1], uses_lsq[fav][1], rs_left, lsq_left);
    rs_left  = rs_left  - {1'b0, f1 & uses_rs[fav][1]};
    lsq_left = lsq_left - {1'b0, f1 & uses_lsq[fav][1]};

    o0       = !f1 && (cap[oth] != 2'd0) && fits(uses_rs[oth][0], uses_lsq[oth][0], rs_left, lsq_left);
    rs_left  = rs_left  - {1'b0, o0 & uses_rs[oth][0]};
    lsq_left = lsq_left - {1'b0, o0 & uses_lsq[oth][0]};

    o1       = !f0 && o0 && (cap[oth] == 2'd2) && fits(uses_rs[oth][1], uses_lsq[oth][1], rs_left, lsq_left);

    gcnt_f = {1'b0, f0} + {1'b0, f1};
    gcnt_o = {1'b0, o0} + {1'b0, o1};
    cons[0] = fav ? gcnt_o : gcnt_f;
    cons[1] = fav ? gcnt_f : gcnt_o;

    sv_c[0] = f0 | o0;
    sv_c[1] = f1 | (f0 & o0) | o1;
    st_c[0] = f0 ? fav : (o0 ? oth : 1'b0);
    st_c[1] = f1 ? fav : (sv_c[1] ? oth : 1'b0);
  end

  assign slot_valid  = reset ? sv_c : 2'b00;
  assign slot_thread = reset ? st_c : 2'b00;
  assign consume_0   = reset ? cons[0] : 2'd0;
  assign consume_1   = reset ? cons[1] : 2'd0;
  assign stall_0     = reset && req_0 && (cons[0] < num_ready_0);
  assign stall_1     = reset && req_1 && (cons[1] < num_ready_1);

  // Slot 0 is always filled when anything is granted, so it stands for "any grant".
  always_comb begin
    rr_d = rr_q;
    if (elig[0] && elig[1] && sv_c[0]) begin
      rr_d = ~rr_q;
    end
    for (int t = 0; t < N_THREADS; t++) begin
      if (elig[t] && (cons[t] == 2'd0)) begin
        starve_d[t] = starve_hit[t] ? starve_q[t] : starve_q[t] + 1'b1;
      end else begin
        starve_d[t] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_q <= 1'b0;
      for (int t = 0; t < N_THREADS; t++) begin
        starve_q[t] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int t = 0; t < N_THREADS; t++) begin
        starve_q[t] <= starve_d[t];
      end
    end
  end

endmodule

// File: tb/tb_smt_dispatch_scheduler.sv
// tb/tb_smt_dispatch_scheduler.sv - self-checking bench for smt_dispatch_scheduler
module tb_smt_dispatch_scheduler;

  localparam int FLUSH_CYCLES = 2;
  localparam int STARVE_LIMIT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_0, req_1;
  logic [1:0] num_ready_0, num_ready_1;
  logic [1:0] uses_RS_0, uses_RS_1, uses_LSQ_0, uses_LSQ_1;
  logic       ROB_0_full, ROB_0_almost_full, ROB_1_full, ROB_1_almost_full;
  logic       RS_full, RS_almost_full, LSQ_full, LSQ_almost_full;
  logic       mispredict_ROB_0, mispredict_ROB_1;
  logic [1:0] slot_valid, slot_thread, consume_0, consume_1;
  logic       stall_0, stall_1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_flush [2];
  int         m_starve[2];
  int         m_rr;
  bit         m_el [2];
  int         m_c  [2];
  logic [1:0] e_sv, e_st;
  logic       e_stall[2];

  smt_dispatch_scheduler #(.FLUSH_CYCLES(FLUSH_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .req_0(req_0), .req_1(req_1),
    .num_ready_0(num_ready_0), .num_ready_1(num_ready_1),
    .uses_RS_0(uses_RS_0), .uses_RS_1(uses_RS_1),
    .uses_LSQ_0(uses_LSQ_0), .uses_LSQ_1(uses_LSQ_1),
    .ROB_0_full(ROB_0_full), .ROB_0_almost_full(ROB_0_almost_full),
    .ROB_1_full(ROB_1_full), .ROB_1_almost_full(ROB_1_almost_full),
    .RS_full(RS_full), .RS_almost_full(RS_almost_full),
    .LSQ_full(LSQ_full), .LSQ_almost_full(LSQ_almost_full),
    .mispredict_ROB_0(mispredict_ROB_0), .mispredict_ROB_1(mispredict_ROB_1),
    .slot_valid(slot_valid), .slot_thread(slot_thread),
    .consume_0(consume_0), .consume_1(consume_1),
    .stall_0(stall_0), .stall_1(stall_1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Greedy fill: favoured thread first, then the other, each oldest-first,
  // stopping a thread at its first instruction that cannot be placed.
  task automatic model_eval();
    int cap[2];
    int order[2];
    int rs, lsq, fav, slot;
    logic [1:0] nr[2], urs[2], ulsq[2];
    logic rq[2], rf[2], raf[2], mp[2];
    nr[0] = num_ready_0;  nr[1] = num_ready_1;
    urs[0] = uses_RS_0;   urs[1] = uses_RS_1;
    ulsq[0] = uses_LSQ_0; ulsq[1] = uses_LSQ_1;
    rq[0] = req_0;        rq[1] = req_1;
    rf[0] = ROB_0_full;   rf[1] = ROB_1_full;
    raf[0] = ROB_0_almost_full; raf[1] = ROB_1_almost_full;
    mp[0] = mispredict_ROB_0;   mp[1] = mispredict_ROB_1;
    e_sv = 2'b00; e_st = 2'b00; m_c[0] = 0; m_c[1] = 0;
    for (int t = 0; t < 2; t++) begin
      m_el[t] = rq[t] && (m_flush[t] == 0) && !rf[t] && !mp[t];
      if (!m_el[t])    cap[t] = 0;
      else if (raf[t]) cap[t] = 1;
      else             cap[t] = (nr[t] > 2) ? 2 : int'(nr[t]);
    end
    rs  = RS_full  ? 0 : (RS_almost_full  ? 1 : 2);
    lsq = LSQ_full ? 0 : (LSQ_almost_full ? 1 : 2);
    if (m_starve[0] == STARVE_LIMIT && m_starve[1] != STARVE_LIMIT)      fav = 0;
    else if (m_starve[1] == STARVE_LIMIT && m_starve[0] != STARVE_LIMIT) fav = 1;
    else                                                                 fav = m_rr;
    order[0] = fav; order[1] = 1 - fav;
    slot = 0;
    for (int i = 0; i < 2; i++) begin
      automatic int t = order[i];
      for (int k = 0; k < cap[t]; k++) begin
        if (slot == 2) break;
        if ((urs[t][k] && rs == 0) || (ulsq[t][k] && lsq == 0)) break;
        if (urs[t][k])  rs--;
        if (ulsq[t][k]) lsq--;
        e_sv[slot] = 1'b1;
        e_st[slot] = (t == 1);
        slot++;
        m_c[t]++;
      end
    end
    for (int t = 0; t < 2; t++) e_stall[t] = rq[t] && (m_c[t] < int'(nr[t]));
    if (!reset) begin
      e_sv = 2'b00; e_st = 2'b00; m_c[0] = 0; m_c[1] = 0;
      e_stall[0] = 1'b0; e_stall[1] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic mp[2];
    mp[0] = mispredict_ROB_0; mp[1] = mispredict_ROB_1;
    if (!reset) begin
      m_rr = 0;
      for (int t = 0; t < 2; t++) begin m_flush[t] = 0; m_starve[t] = 0; end
    end else begin
      if (m_el[0] && m_el[1] && (m_c[0] + m_c[1] > 0)) m_rr = 1 - m_rr;
      for (int t = 0; t < 2; t++) begin
        if (m_el[t] && m_c[t] == 0)
          m_starve[t] = (m_starve[t] < STARVE_LIMIT) ? m_starve[t] + 1 : STARVE_LIMIT;
        else
          m_starve[t] = 0;
        if (mp[t])              m_flush[t] = FLUSH_CYCLES;
        else if (m_flush[t] > 0) m_flush[t] = m_flush[t] - 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_eval();
    chk("slot_valid",  32'(slot_valid), 32'(e_sv));
    chk("slot_thread", 32'(slot_thread & slot_valid), 32'(e_st));
    chk("consume_0",   32'(consume_0), 32'(m_c[0]));
    chk("consume_1",   32'(consume_1), 32'(m_c[1]));
    chk("stall_0",     32'(stall_0), 32'(e_stall[0]));
    chk("stall_1",     32'(stall_1), 32'(e_stall[1]));
    chk("packed",      32'(slot_valid == 2'b10), 32'(0));
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic quiet();
    reset = 1'b1;
    req_0 = 0; req_1 = 0; num_ready_0 = 0; num_ready_1 = 0;
    uses_RS_0 = 0; uses_RS_1 = 0; uses_LSQ_0 = 0; uses_LSQ_1 = 0;
    ROB_0_full = 0; ROB_0_almost_full = 0; ROB_1_full = 0; ROB_1_almost_full = 0;
    RS_full = 0; RS_almost_full = 0; LSQ_full = 0; LSQ_almost_full = 0;
    mispredict_ROB_0 = 0; mispredict_ROB_1 = 0;
  endtask

  task automatic both_ready();
    req_0 = 1; req_1 = 1; num_ready_0 = 2; num_ready_1 = 2;
  endtask

  initial begin
    for (int t = 0; t < 2; t++) begin m_flush[t] = 0; m_starve[t] = 0; end
    m_rr = 0;
    quiet();

    // Reset holds outputs quiet even with requests present
    reset = 0; both_ready();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_slot_valid", 32'(slot_valid), 32'(0));
      chk("rst_stall_0", 32'(stall_0), 32'(0));
      advance();
    end

    // Both threads, full width, rr_ptr starts at 0
    quiet(); both_ready();
    sample();
    chk("r20_thread", 32'(slot_thread), 32'(2'b00));
    chk("r20_c0", 32'(consume_0), 32'(2));
    chk("r20_c1", 32'(consume_1), 32'(0));
    chk("r20_stall1", 32'(stall_1), 32'(1));
    advance();
    sample();
    chk("r20_next_thread", 32'(slot_thread), 32'(2'b11));
    advance();

    // ROB almost full on thread 0 with rr_ptr back at 0
    ROB_0_almost_full = 1;
    sample();
    chk("r21_thread", 32'(slot_thread), 32'(2'b10));
    chk("r21_c0", 32'(consume_0), 32'(1));
    chk("r21_c1", 32'(consume_1), 32'(1));
    advance();

    // RS almost full, both of thread 0's instructions need RS
    quiet(); req_0 = 1; num_ready_0 = 2; RS_almost_full = 1; uses_RS_0 = 2'b11;
    sample();
    chk("r22_c0", 32'(consume_0), 32'(1));
    chk("r22_valid", 32'(slot_valid), 32'(2'b01));
    chk("r22_stall0", 32'(stall_0), 32'(1));
    advance();

    // Mispredict pulse on thread 0
    quiet(); both_ready(); mispredict_ROB_0 = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) num_ready_1 = 1;
      sample();
      if (i < 3) begin
        chk("r23_blocked_c0", 32'(consume_0), 32'(0));
        chk("r23_t1_runs", 32'(consume_1 != 0), 32'(1));
      end else begin
        chk("r23_resume_c0", 32'(consume_0 != 0), 32'(1));
      end
      advance();
      mispredict_ROB_0 = 0;
    end

    // Thread 1 starved by LSQ_full, then favoured once released
    quiet(); both_ready(); uses_LSQ_1 = 2'b11; LSQ_full = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("r24_c1_zero", 32'(consume_1), 32'(0));
      chk("r24_c0_two", 32'(consume_0), 32'(2));
      advance();
    end
    if (m_rr != 0) begin
      sample();
      advance();
    end
    LSQ_full = 0;
    sample();
    chk("r24_fav_slot0", 32'(slot_valid[0] & slot_thread[0]), 32'(1));
    advance();

    // Reset in the first FLUSH cycle
    quiet(); req_1 = 1; num_ready_1 = 2; mispredict_ROB_1 = 1;
    sample();
    chk("r25_mp_c1", 32'(consume_1), 32'(0));
    advance();
    mispredict_ROB_1 = 0; reset = 0;
    sample();
    chk("r25_rst_valid", 32'(slot_valid), 32'(0));
    advance();
    reset = 1;
    sample();
    chk("r25_after_c1", 32'(consume_1), 32'(2));
    advance();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      num_ready_0 = 2'($urandom_range(0, 2)); req_0 = (num_ready_0 != 0);
      num_ready_1 = 2'($urandom_range(0, 2)); req_1 = (num_ready_1 != 0);
      uses_RS_0 = 2'($urandom); uses_RS_1 = 2'($urandom);
      uses_LSQ_0 = 2'($urandom); uses_LSQ_1 = 2'($urandom);
      ROB_0_full = ($urandom_range(0, 7) == 0); ROB_0_almost_full = ($urandom_range(0, 3) == 0);
      ROB_1_full = ($urandom_range(0, 7) == 0); ROB_1_almost_full = ($urandom_range(0, 3) == 0);
      RS_full = ($urandom_range(0, 5) == 0);  RS_almost_full = ($urandom_range(0, 2) == 0);
      LSQ_full = ($urandom_range(0, 3) == 0); LSQ_almost_full = ($urandom_range(0, 2) == 0);
      mispredict_ROB_0 = ($urandom_range(0, 15) == 0);
      mispredict_ROB_1 = ($urandom_range(0, 15) == 0);
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
